mem_access_unit: RTL and testbench

Multi-cycle load/store sequencer between the datapath's load/store control logic and the word-addressed synchronous memory. It accepts one byte, halfword or word access at a time and issues aligned word reads/writes. Sub-word stores are done as read-modify-write, and load data comes back zero-extended and right-justified. It replaces direct memory strobing from the main control FSM with a ready/valid request and a one-cycle response pulse.

---
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time byte/half/word load/store sequencer in front
// of a word-addressed synchronous memory. Sub-word stores are read-modify-write;
// loads return the selected lane zero-extended and right-justified.
// Optional build macro: MAU_ALIGN_CHECK_EN adds the misalign output and
// completes misaligned half/word requests immediately without touching memory.
module mem_access_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef MAU_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  // WAIT lasts MEM_LATENCY-1 cycles; the counter is loaded with one less than that.
  localparam logic [1:0] WAIT_INIT    = (MEM_LATENCY > 1) ? 2'(MEM_LATENCY - 2) : 2'd0;
  localparam bit         SINGLE_CYCLE = (MEM_LATENCY == 1);

  state_t      state_q, state_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        write_q;

  logic        accept;
  logic        capture;
  logic        req_misaligned;
  logic [31:0] cur_addr;

  logic        resp_valid_d, mem_rd_d, mem_wr_d;
  logic [31:0] resp_rdata_d, mem_addr_d, mem_wdata_d;
`ifdef MAU_ALIGN_CHECK_EN
  logic        misalign_d;
`endif

  // Size code 00 behaves as a full word.
  function automatic logic is_word(input logic [1:0] sz);
    return (sz == 2'b11) || (sz == 2'b00);
  endfunction

  // Replace only the addressed lane of the old word with right-justified store data.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] wd,
                                             input logic [1:0] lane, input logic [1:0] sz);
    logic [31:0] w;
    w = old_w;
    if (sz == 2'b01)      w[8*lane +: 8]      = wd[7:0];
    else if (sz == 2'b10) w[16*lane[1] +: 16] = wd[15:0];
    else                  w                   = wd;
    return w;
  endfunction

  // Pull the addressed lane down to bit 0 and zero-extend it.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      2'b01:   r = {24'b0, w[8*lane +: 8]};
      2'b10:   r = {16'b0, w[16*lane[1] +: 16]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && (state_q == S_IDLE);
  // The old/read word is taken on the last cycle of the memory latency window.
  assign capture   = ((state_q == S_READ) && SINGLE_CYCLE) ||
                     ((state_q == S_WAIT) && (wait_cnt_q == 2'd0));
  assign cur_addr  = (state_q == S_IDLE) ? req_addr : addr_q;

`ifdef MAU_ALIGN_CHECK_EN
  assign req_misaligned = ((req_size == 2'b10) && req_addr[0]) ||
                          (is_word(req_size) && (req_addr[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  // State register and latency counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Request latch: captured once on accept, held until the next IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      write_q <= req_write;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_misaligned)                          state_d = S_DONE;
          else if (req_write && is_word(req_size))     state_d = S_WRITE;
          else                                         state_d = S_READ;
        end
      end
      S_READ: begin
        if (SINGLE_CYCLE) begin
          state_d = write_q ? S_WRITE : S_DONE;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 2'd0) state_d = write_q ? S_WRITE : S_DONE;
        else                    wait_cnt_d = wait_cnt_q - 2'd1;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    mem_rd_d     = (state_d == S_READ);
    mem_wr_d     = (state_d == S_WRITE);
    resp_valid_d = (state_d == S_DONE);
    mem_addr_d   = (state_d inside {S_READ, S_WAIT, S_WRITE}) ? {cur_addr[31:2], 2'b00} : '0;
    mem_wdata_d  = '0;
    if (state_d == S_WRITE)
      mem_wdata_d = capture ? merge_word(mem_rdata, wdata_q, addr_q[1:0], size_q) : req_wdata;
    resp_rdata_d = '0;
    if (capture && !write_q)
      resp_rdata_d = extract(mem_rdata, addr_q[1:0], size_q);
`ifdef MAU_ALIGN_CHECK_EN
    misalign_d = accept && req_misaligned;
`endif
  end

  // Output registers; reset clears every strobe and data output.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
`ifdef MAU_ALIGN_CHECK_EN
      misalign   <= 1'b0;
`endif
    end else begin
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      mem_addr   <= mem_addr_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      mem_wdata  <= mem_wdata_d;
`ifdef MAU_ALIGN_CHECK_EN
      misalign   <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (MEM_LATENCY 1 and 3), each with its
// own behavioural memory, checked against a byte-array reference model.
module tb_mem_access_unit;

  logic        clk;
  int          cyc;
  int          n_checks;
  int          n_fails;
  logic        mem_init;

  logic        dut_reset [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic [31:0] mem_addr  [2];
  logic        mem_rd    [2];
  logic        mem_wr    [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
`ifdef MAU_ALIGN_CHECK_EN
  logic        misalign  [2];
`endif

  logic [7:0]  ref_bytes [512];
  logic [31:0] last_rdata[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'(i * 32'h9E3779B9) ^ 32'h5A5AF00F;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_mem
    localparam int LAT = (gi == 0) ? 1 : 3;
    localparam int HI  = (LAT > 1) ? LAT - 2 : 0;
    logic [31:0] mem [128];
    logic        hv  [4];
    logic [31:0] ha  [4];
    logic [31:0] junk;
    logic        due;
    logic [31:0] due_addr;

    mem_access_unit #(.MEM_LATENCY(LAT)) u_dut (
      .clock     (clk),
      .reset     (dut_reset[gi]),
      .req_valid (req_valid[gi]),
      .req_ready (req_ready[gi]),
      .req_write (req_write[gi]),
      .req_size  (req_size[gi]),
      .req_addr  (req_addr[gi]),
      .req_wdata (req_wdata[gi]),
      .resp_valid(resp_valid[gi]),
      .resp_rdata(resp_rdata[gi]),
      .mem_addr  (mem_addr[gi]),
      .mem_rd    (mem_rd[gi]),
      .mem_wr    (mem_wr[gi]),
      .mem_wdata (mem_wdata[gi]),
      .mem_rdata (mem_rdata[gi])
`ifdef MAU_ALIGN_CHECK_EN
      ,
      .misalign  (misalign[gi])
`endif
    );

    // Memory: data for a read shows up LAT-1 cycles after the strobe cycle, junk otherwise.
    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
      end else if (mem_wr[gi]) begin
        mem[mem_addr[gi][8:2]] <= mem_wdata[gi];
      end
      hv[0] <= mem_rd[gi];
      ha[0] <= mem_addr[gi];
      for (int k = 1; k < 4; k++) begin
        hv[k] <= hv[k-1];
        ha[k] <= ha[k-1];
      end
      junk <= $urandom;
    end
    assign due            = (LAT == 1) ? mem_rd[gi] : hv[HI];
    assign due_addr       = (LAT == 1) ? mem_addr[gi] : ha[HI];
    assign mem_rdata[gi]  = due ? mem[due_addr[8:2]] : junk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_word(input logic [1:0] sz);
    return (sz == 2'b11) || (sz == 2'b00);
  endfunction

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    bit m;
    m = ((sz == 2'b10) && a[0]) || (is_word(sz) && (a[1:0] != 2'b00));
`ifdef MAU_ALIGN_CHECK_EN
    return m;
`else
    return m && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_word(input int wa);
    return {ref_bytes[wa+3], ref_bytes[wa+2], ref_bytes[wa+1], ref_bytes[wa]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input int a);
    int hb;
    hb = (a / 2) * 2;
    if (sz == 2'b01) return {24'b0, ref_bytes[a]};
    if (sz == 2'b10) return {16'b0, ref_bytes[hb+1], ref_bytes[hb]};
    return ref_word((a / 4) * 4);
  endfunction

  task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
    int hb, wb;
    hb = (a / 2) * 2;
    wb = (a / 4) * 4;
    if (sz == 2'b01) begin
      ref_bytes[a] = wd[7:0];
    end else if (sz == 2'b10) begin
      ref_bytes[hb]   = wd[7:0];
      ref_bytes[hb+1] = wd[15:8];
    end else begin
      for (int k = 0; k < 4; k++) ref_bytes[wb+k] = wd[8*k +: 8];
    end
  endtask

  task automatic drive(input int d, input bit w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    req_write[d] = w;
    req_size[d]  = sz;
    req_addr[d]  = a;
    req_wdata[d] = wd;
  endtask

  // One access on both instances, monitored cycle by cycle for 8 cycles after accept.
  task automatic do_txn(input int id, input bit w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
    int          ai;
    bit          mis;
    logic [31:0] exp_rd, exp_word, exp_addr;
    int          exp_rdn, exp_wrn;
    int          lat[2], exp_wc[2];
    int          rd_n[2], wr_n[2], resp_n[2], rd_c[2], wr_c[2], resp_c[2];
    ai       = int'(a[8:0]);
    mis      = is_mis(sz, a);
    exp_rd   = (w || mis) ? 32'h0 : ref_load(sz, ai);
    if (w && !mis) ref_store(sz, ai, wd);
    exp_word = ref_word((ai / 4) * 4);
    exp_addr = {a[31:2], 2'b00};
    exp_rdn  = (!mis && (!w || !is_word(sz))) ? 1 : 0;
    exp_wrn  = (!mis && w) ? 1 : 0;
    for (int d = 0; d < 2; d++) begin
      if (mis)              lat[d] = 1;
      else if (!w)          lat[d] = lat_of(d) + 1;
      else if (is_word(sz)) lat[d] = 2;
      else                  lat[d] = lat_of(d) + 2;
      exp_wc[d] = is_word(sz) ? 1 : lat_of(d) + 1;
      rd_n[d] = 0; wr_n[d] = 0; resp_n[d] = 0;
      rd_c[d] = -1; wr_c[d] = -1; resp_c[d] = -1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("ready_idle", 32'(req_ready[d]), 32'd1);
      drive(d, w, sz, a, wd);
      req_valid[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      drive(d, ~w, ~sz, ~a, ~wd);
    end
    for (int c = 1; c <= 8; c++) begin
      for (int d = 0; d < 2; d++) begin
        check_eq("ready", 32'(req_ready[d]), 32'(c > lat[d]));
        if (mem_rd[d] || mem_wr[d]) begin
          check_eq("strobe_excl", 32'(mem_rd[d] & mem_wr[d]), 32'd0);
          check_eq("mem_addr", mem_addr[d], exp_addr);
        end
        if (mem_rd[d]) begin
          if (rd_n[d] == 0) rd_c[d] = c;
          rd_n[d]++;
        end
        if (mem_wr[d]) begin
          wr_c[d] = c;
          wr_n[d]++;
          check_eq("mem_wdata", mem_wdata[d], exp_word);
        end
        if (resp_valid[d]) begin
          resp_c[d] = c;
          resp_n[d]++;
          last_rdata[d] = resp_rdata[d];
          check_eq("resp_rdata", resp_rdata[d], exp_rd);
          check_eq("resp_mem_addr", mem_addr[d], 32'h0);
`ifdef MAU_ALIGN_CHECK_EN
          check_eq("misalign", 32'(misalign[d]), 32'(mis));
`endif
        end
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      check_eq("resp_count", 32'(resp_n[d]), 32'd1);
      check_eq("resp_cycle", 32'(resp_c[d]), 32'(lat[d]));
      check_eq("rd_count", 32'(rd_n[d]), 32'(exp_rdn));
      if (exp_rdn != 0) check_eq("rd_cycle", 32'(rd_c[d]), 32'd1);
      check_eq("wr_count", 32'(wr_n[d]), 32'(exp_wrn));
      if (exp_wrn != 0) check_eq("wr_cycle", 32'(wr_c[d]), 32'(exp_wc[d]));
    end
    $display("txn %0d: %s size=%0d addr=%h wdata=%h rdata L1=%h L3=%h", id,
             w ? "store" : "load ", sz, a, wd, last_rdata[0], last_rdata[1]);
  endtask

  task automatic check_quiet(input string tag, input int d);
    check_eq({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
    check_eq({tag, "_resp_rdata"}, resp_rdata[d], 32'h0);
    check_eq({tag, "_mem_rd"}, 32'(mem_rd[d]), 32'd0);
    check_eq({tag, "_mem_wr"}, 32'(mem_wr[d]), 32'd0);
    check_eq({tag, "_mem_addr"}, mem_addr[d], 32'h0);
    check_eq({tag, "_mem_wdata"}, mem_wdata[d], 32'h0);
`ifdef MAU_ALIGN_CHECK_EN
    check_eq({tag, "_misalign"}, 32'(misalign[d]), 32'd0);
`endif
  endtask

  // Byte store interrupted by reset: L1 instance in READ, L3 instance in WAIT.
  task automatic reset_midop();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b1, 2'b01, 32'h41, 32'h55);
      req_valid[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      check_eq("rst_c1_wr", 32'(mem_wr[d]), 32'd0);
    end
    dut_reset[0] = 1'b1;
    @(negedge clk);
    check_quiet("rst_l1", 0);
    check_eq("rst_c2_wr_l3", 32'(mem_wr[1]), 32'd0);
    dut_reset[0] = 1'b0;
    dut_reset[1] = 1'b1;
    #1;
    check_eq("rst_ready_l1", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    check_quiet("rst_l3", 1);
    dut_reset[1] = 1'b0;
    #1;
    check_eq("rst_ready_l3", 32'(req_ready[1]), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check_quiet("rst_after", d);
        check_eq("rst_after_ready", 32'(req_ready[d]), 32'd1);
      end
    end
    $display("txn reset-midop: byte store 0x55 at 0x41 aborted");
  endtask

  // Three loads with req_valid held high; inputs move to the next load right after each accept.
  task automatic back_to_back();
    logic [1:0]  bs [3];
    logic [31:0] ba [3];
    logic [31:0] be [3];
    int na[2], nr[2], lastacc[2];
    bs[0] = 2'b01; ba[0] = 32'h102;
    bs[1] = 2'b11; ba[1] = 32'h020;
    bs[2] = 2'b10; ba[2] = 32'h1A6;
    for (int k = 0; k < 3; k++) be[k] = ref_load(bs[k], int'(ba[k][8:0]));
    for (int d = 0; d < 2; d++) begin
      na[d] = 0; nr[d] = 0; lastacc[d] = 0;
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (resp_valid[d]) begin
          if (nr[d] < 3) check_eq("b2b_rdata", resp_rdata[d], be[nr[d]]);
          else           check_eq("b2b_extra_resp", 32'(nr[d]), 32'd2);
          nr[d]++;
        end
        if (req_valid[d] && req_ready[d]) begin
          if (na[d] > 0) check_eq("b2b_gap", 32'(cyc - lastacc[d]), 32'(lat_of(d) + 2));
          lastacc[d] = cyc;
          na[d]++;
        end
        if (na[d] < 3) begin
          drive(d, 1'b0, bs[na[d]], ba[na[d]], 32'hFFFF_FFFF);
          req_valid[d] = 1'b1;
        end else begin
          req_valid[d] = 1'b0;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      check_eq("b2b_accepts", 32'(na[d]), 32'd3);
      check_eq("b2b_resps", 32'(nr[d]), 32'd3);
    end
    $display("txn back-to-back: 3 loads, resp L1=%0d L3=%0d", nr[0], nr[1]);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    mem_init = 1'b1;
    for (int d = 0; d < 2; d++) begin
      dut_reset[d] = 1'b1;
      req_valid[d] = 1'b0;
      drive(d, 1'b0, 2'b00, 32'h0, 32'h0);
      last_rdata[d] = '0;
    end
    for (int i = 0; i < 128; i++)
      for (int k = 0; k < 4; k++) ref_bytes[4*i+k] = init_word(i)[8*k +: 8];
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_quiet("reset", d);
      check_eq("reset_ready", 32'(req_ready[d]), 32'd0);
    end
    mem_init = 1'b0;
    for (int d = 0; d < 2; d++) dut_reset[d] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check_eq("ready_after_reset", 32'(req_ready[d]), 32'd1);

    do_txn(0, 1'b1, 2'b11, 32'h100, 32'h11223344);
    do_txn(1, 1'b0, 2'b01, 32'h102, 32'h0);
    for (int d = 0; d < 2; d++) check_eq("plan_byte_ld", last_rdata[d], 32'h00000022);
    do_txn(2, 1'b1, 2'b10, 32'h102, 32'h0000BEEF);
    do_txn(3, 1'b0, 2'b11, 32'h100, 32'h0);
    for (int d = 0; d < 2; d++) check_eq("plan_word_ld", last_rdata[d], 32'hBEEF3344);
    do_txn(4, 1'b1, 2'b11, 32'h020, 32'hCAFEF00D);
    do_txn(5, 1'b0, 2'b01, 32'h023, 32'h0);
    for (int d = 0; d < 2; d++) check_eq("plan_l3_byte", last_rdata[d], 32'h000000CA);
    do_txn(6, 1'b0, 2'b11, 32'h101, 32'h0);
    do_txn(7, 1'b0, 2'b00, 32'h022, 32'h0);
    do_txn(8, 1'b1, 2'b01, 32'h103, 32'h000000A5);
    do_txn(9, 1'b0, 2'b10, 32'h101, 32'h0);

    reset_midop();
    back_to_back();

    for (int t = 10; t < 160; t++)
      do_txn(t, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             32'($urandom_range(0, 511)), $urandom);

    for (int i = 0; i < 128; i++) begin
      check_eq("mem_l1", g_mem[0].mem[i], ref_word(4*i));
      check_eq("mem_l3", g_mem[1].mem[i], ref_word(4*i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
